// File: rtl/adder4_arbiter.sv
// adder4_arbiter: two-requester round-robin arbiter in front of a registered 4-bit adder.
// Define ADDER4_ARBITER_SAT_EN to saturate the sum at F on overflow.
module adder4_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt1,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [3:0] sum,
    output logic       cout,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state_q, state_d;
    logic       last_q, resp_id_q, cout_q, grant, win;
    logic [3:0] a_q, b_q, sum_q;
    logic [4:0] raw, res;
    // Gated by rst_n so no grant is visible while reset is held.
    always_comb begin
        grant   = rst_n && state_q == IDLE && (req0 || req1);
        win     = (req0 && req1) ? !last_q : req1;
        gnt0    = grant && !win;
        gnt1    = grant && win;
        state_d = state_q == IDLE ? (grant ? EXEC : IDLE) : state_q == EXEC ? RESP : IDLE;
        raw     = {1'b0, a_q} + {1'b0, b_q};
`ifdef ADDER4_ARBITER_SAT_EN
        res     = raw[4] ? 5'h1F : raw;
`else
        res     = raw;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= (FIRST_PRIO == 0);
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            resp_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                a_q    <= win ? a1 : a0;
                b_q    <= win ? b1 : b0;
                last_q <= win;
            end
            if (state_q == EXEC) begin
                {cout_q, sum_q} <= res;
                resp_id_q       <= last_q;
            end
        end
    end
    assign resp_valid = state_q == RESP;
    assign busy       = state_q != IDLE;
    assign resp_id    = resp_id_q;
    assign sum        = sum_q;
    assign cout       = cout_q;
endmodule

// File: tb/tb_adder4_arbiter.sv
// tb_adder4_arbiter: directed and random requests checked against a transaction-level model.
module tb_adder4_arbiter;
    logic       clk = 0, rst_n = 0, req0 = 0, req1 = 0;
    logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic       gnt0, gnt1, resp_valid, resp_id, cout, busy;
    logic [3:0] sum;
    int checks = 0, errors = 0;
    int phase = 0;
    logic       last_m = 1, m_id = 0, m_cout = 0, p_id = 0;
    logic [3:0] m_sum = 0;
    logic [4:0] p_res = 0;

    adder4_arbiter #(.FIRST_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .resp_valid(resp_valid), .resp_id(resp_id), .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_add(input logic [3:0] a, input logic [3:0] b);
        int s = int'(a) + int'(b);
`ifdef ADDER4_ARBITER_SAT_EN
        if (s > 15) return 5'h1F;
`endif
        return 5'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic g, w;
        @(negedge clk);
        g = phase == 0 && (req0 || req1);
        w = (req0 && req1) ? ~last_m : req1;
        chk("gnt0", gnt0, g && !w);
        chk("gnt1", gnt1, g && w);
        chk("busy", busy, phase != 0);
        chk("resp_valid", resp_valid, phase == 2);
        chk("resp_id", resp_id, m_id);
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        @(posedge clk);
        if (phase == 1) begin
            {m_cout, m_sum} = p_res;
            m_id  = p_id;
            phase = 2;
        end else if (phase == 2) phase = 0;
        else if (g) begin
            p_res  = w ? ref_add(a1, b1) : ref_add(a0, b0);
            p_id   = w;
            last_m = w;
            phase  = 1;
        end
        #1;
        if (g && !w) req0 = 0;
        if (g && w) req1 = 0;
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        phase = 0; last_m = 1; m_id = 0; m_sum = 0; m_cout = 0;
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        req0 = 1;
        do_reset();
        repeat (3) step();
        chk("single_default_sum", sum, 0);
        // single request
        req0 = 1; a0 = 3; b0 = 4;
        repeat (3) step();
        chk("req022_sum", sum, 7);
        chk("req022_id", resp_id, 0);
        // simultaneous requests right after reset
        do_reset();
        req0 = 1; a0 = 1; b0 = 1; req1 = 1; a1 = 2; b1 = 2;
        repeat (3) step();
        chk("req023_first_sum", sum, 2);
        chk("req023_first_id", resp_id, 0);
        repeat (3) step();
        chk("req023_second_sum", sum, 4);
        chk("req023_second_id", resp_id, 1);
        // overflow and boundaries
        req0 = 1; a0 = 4'hF; b0 = 4'h1;
        repeat (3) step();
        chk("req024_cout", cout, 1);
`ifdef ADDER4_ARBITER_SAT_EN
        chk("req024_sum", sum, 4'hF);
`else
        chk("req024_sum", sum, 4'h0);
`endif
        req1 = 1; a1 = 4'hF; b1 = 4'hF;
        repeat (3) step();
        chk("ff_cout", cout, 1);
`ifdef ADDER4_ARBITER_SAT_EN
        chk("ff_sum", sum, 4'hF);
`else
        chk("ff_sum", sum, 4'hE);
`endif
        req0 = 1; a0 = 0; b0 = 0;
        repeat (3) step();
        chk("zero_sum", sum, 0);
        chk("zero_cout", cout, 0);
        // operand change after grant
        req1 = 1; a1 = 5; b1 = 5;
        step();
        a1 = 0;
        repeat (2) step();
        chk("req025_sum", sum, 4'hA);
        chk("req025_cout", cout, 0);
        // reset during EXEC
        req0 = 1; a0 = 7; b0 = 6;
        step();
        do_reset();
        repeat (3) step();
        req0 = 1; a0 = 2; b0 = 9;
        repeat (3) step();
        chk("req026_sum", sum, 4'hB);
        // request while busy
        req0 = 1; a0 = 1; b0 = 2;
        step();
        req1 = 1; a1 = 3; b1 = 3;
        repeat (5) step();
        chk("req027_sum", sum, 6);
        chk("req027_id", resp_id, 1);
        // random traffic
        repeat (600) begin
            if (!req0) begin
                a0 = 4'($urandom); b0 = 4'($urandom);
                req0 = ($urandom % 3) == 0;
            end
            if (!req1) begin
                a1 = 4'($urandom); b1 = 4'($urandom);
                req1 = ($urandom % 3) == 0;
            end
            if ($urandom % 101 == 0) do_reset();
            step();
        end
        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
